// File: rtl/paddle_ctrl_accel.sv
// Per-player Pong paddle: IDLE/READY/PLAY gate, per-frame velocity ramp,
// manual or ball-tracking steering, and a registered paddle pixel/colour.
module paddle_ctrl_accel #(
  parameter int         ACTIVE_COLS  = 640,
  parameter int         ACTIVE_ROWS  = 480,
  parameter int         PADDLE_X     = 32,
  parameter int         PADDLE_W     = 8,
  parameter int         PADDLE_H     = 64,
  parameter int         MIN_SPEED    = 2,
  parameter int         MAX_SPEED    = 8,
  parameter int         DEADBAND     = 4,
  parameter logic [8:0] PADDLE_COLOR = 9'h1FF
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_H_count,
  input  logic [9:0] i_V_count,
  input  logic       i_Up_Ctrl,
  input  logic       i_Down_Ctrl,
  input  logic       i_Ready,
  input  logic       i_Start,
  input  logic       i_Mode,
  input  logic [9:0] i_Ball_Y,
  output logic [9:0] o_Paddle_Y,
  output logic [1:0] o_State,
  output logic       o_Active,
  output logic [2:0] o_Red,
  output logic [2:0] o_Green,
  output logic [2:0] o_Blue
);

  localparam logic [10:0] Y_MAX  = 11'(ACTIVE_ROWS - PADDLE_H);
  localparam logic [9:0]  Y_HOME = 10'((ACTIVE_ROWS - PADDLE_H) / 2);
  localparam logic [9:0]  V_MIN  = 10'(MIN_SPEED);
  localparam logic [9:0]  V_MAX  = 10'(MAX_SPEED);
  localparam logic [10:0] X_LO   = 11'(PADDLE_X);
  localparam logic [10:0] X_HI   = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] COLS   = 11'(ACTIVE_COLS);
  localparam logic [10:0] HALF_H = 11'(PADDLE_H / 2);
  localparam logic [10:0] SIZE_H = 11'(PADDLE_H);
  localparam logic [10:0] DB     = 11'(DEADBAND);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READY = 2'd1, S_PLAY = 2'd2, S_BAD = 2'd3} state_t;
  typedef enum logic [1:0] {D_NONE = 2'd0, D_UP = 2'd1, D_DOWN = 2'd2} dir_t;

  state_t             r_State, w_State_Next;
  dir_t               r_Last_Dir, w_Dir;
  logic               r_Last_Mode;
  logic [9:0]         r_Y, r_Vel, w_Speed, w_Vel_Inc;
  logic               r_Active;
  logic [8:0]         r_Rgb;
  logic               w_Tick, w_Active, w_Clamp;
  logic [10:0]        w_Centre, w_Ball, w_H, w_V, w_Y;
  logic signed [10:0] w_Next;
  logic [9:0]         w_Y_Clamped;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_State <= S_IDLE;
    else         r_State <= w_State_Next;
  end

  // Start is only honoured from READY, so Ready+Start together in IDLE stops at READY.
  always_comb begin
    w_State_Next = r_State;
    case (r_State)
      S_IDLE:  if (i_Ready) w_State_Next = S_READY;
      S_READY: if (i_Start) w_State_Next = S_PLAY;
      S_PLAY:  w_State_Next = S_PLAY;
      default: w_State_Next = S_IDLE;
    endcase
  end

  assign w_Tick   = (i_H_count == 10'd0) && (i_V_count == 10'(ACTIVE_ROWS));
  assign w_Y      = {1'b0, r_Y};
  assign w_Centre = w_Y + HALF_H;
  assign w_Ball   = {1'b0, i_Ball_Y};

  always_comb begin
    w_Dir = D_NONE;
    if (i_Mode) begin
      if (w_Centre > w_Ball + DB)      w_Dir = D_UP;
      else if (w_Centre + DB < w_Ball) w_Dir = D_DOWN;
    end else begin
      if (i_Up_Ctrl && !i_Down_Ctrl)      w_Dir = D_UP;
      else if (i_Down_Ctrl && !i_Up_Ctrl) w_Dir = D_DOWN;
    end
  end

  // A continued direction in the same mode keeps the ramp; anything else restarts it.
  assign w_Speed   = ((w_Dir == r_Last_Dir) && (i_Mode == r_Last_Mode)) ? r_Vel : V_MIN;
  assign w_Vel_Inc = (w_Speed >= V_MAX) ? V_MAX : w_Speed + 10'd1;

  always_comb begin
    w_Next      = $signed(w_Y);
    w_Clamp     = 1'b0;
    w_Y_Clamped = r_Y;
    if (w_Dir == D_UP)        w_Next = $signed(w_Y) - $signed({1'b0, w_Speed});
    else if (w_Dir == D_DOWN) w_Next = $signed(w_Y) + $signed({1'b0, w_Speed});
    if (w_Next < 0) begin
      w_Clamp     = 1'b1;
      w_Y_Clamped = 10'd0;
    end else if (w_Next > $signed(Y_MAX)) begin
      w_Clamp     = 1'b1;
      w_Y_Clamped = Y_MAX[9:0];
    end else begin
      w_Y_Clamped = w_Next[9:0];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Y         <= Y_HOME;
      r_Vel       <= V_MIN;
      r_Last_Dir  <= D_NONE;
      r_Last_Mode <= 1'b0;
    end else if (r_State == S_PLAY && w_Tick) begin
      r_Last_Dir  <= w_Dir;
      r_Last_Mode <= i_Mode;
      if (w_Dir == D_NONE) begin
        r_Vel <= V_MIN;
      end else begin
        r_Y   <= w_Y_Clamped;
        r_Vel <= w_Clamp ? V_MIN : w_Vel_Inc;
      end
    end
  end

  assign w_H      = {1'b0, i_H_count};
  assign w_V      = {1'b0, i_V_count};
  assign w_Active = (w_H >= X_LO) && (w_H < X_HI) && (w_H < COLS) &&
                    (w_V >= w_Y) && (w_V < w_Y + SIZE_H);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Active <= 1'b0;
      r_Rgb    <= 9'd0;
    end else begin
      r_Active <= w_Active;
      r_Rgb    <= w_Active ? PADDLE_COLOR : 9'd0;
    end
  end

  assign o_Paddle_Y = r_Y;
  assign o_State    = r_State;
  assign o_Active   = r_Active;
  assign o_Red      = r_Rgb[8:6];
  assign o_Green    = r_Rgb[5:3];
  assign o_Blue     = r_Rgb[2:0];

endmodule

// File: tb/tb_paddle_ctrl_accel.sv
// Directed bench for paddle_ctrl_accel: frame ticks are driven directly as
// H=0/V=480 cycles instead of scanning whole frames.
module tb_paddle_ctrl_accel;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hc = 10'd1, vc = 10'd0;
  logic       up = 1'b0, dn = 1'b0, rdy = 1'b0, st = 1'b0, mode = 1'b0;
  logic [9:0] ball = 10'd0;
  logic [9:0] py;
  logic [1:0] state;
  logic       act;
  logic [2:0] r, g, b;

  int n_pass = 0;
  int n_total = 0;

  paddle_ctrl_accel dut (
    .i_Clk(clk), .i_Reset(rst), .i_H_count(hc), .i_V_count(vc),
    .i_Up_Ctrl(up), .i_Down_Ctrl(dn), .i_Ready(rdy), .i_Start(st),
    .i_Mode(mode), .i_Ball_Y(ball), .o_Paddle_Y(py), .o_State(state),
    .o_Active(act), .o_Red(r), .o_Green(g), .o_Blue(b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    hc = 10'd0; vc = 10'd480;
    cyc();
    hc = 10'd1; vc = 10'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic pulse(input logic pr, input logic ps);
    rdy = pr; st = ps; cyc(); rdy = 1'b0; st = 1'b0;
  endtask

  initial begin
    int accel [9];
    int autoy [20];
    accel = '{206, 203, 199, 194, 188, 181, 173, 165, 157};
    autoy = '{206, 203, 199, 194, 188, 181, 173, 165, 157, 149,
              141, 133, 125, 117, 109, 101, 93, 85, 77, 69};
    cyc();
    do_reset();
    check("reset_state", state, 0);
    check("reset_y", py, 208);
    check("reset_active", act, 0);
    check("reset_rgb", {r, g, b}, 0);

    hc = 10'd34; vc = 10'd210; cyc();
    check("pix_in_rgb", {r, g, b}, 9'h1FF);
    check("pix_in_active", act, 1);
    hc = 10'd40; vc = 10'd210; cyc();
    check("pix_right_edge", {r, g, b}, 0);
    hc = 10'd32; vc = 10'd207; cyc();
    check("pix_above_top", act, 0);
    hc = 10'd39; vc = 10'd271; cyc();
    check("pix_bottom_row", act, 1);
    hc = 10'd1; vc = 10'd0;

    // Gating in IDLE and READY
    up = 1'b1;
    repeat (3) tick();
    check("idle_hold_y", py, 208);
    pulse(1'b0, 1'b1);
    check("idle_start_ignored", state, 0);
    pulse(1'b1, 1'b0);
    check("ready_state", state, 1);
    repeat (3) tick();
    check("ready_hold_y", py, 208);
    pulse(1'b0, 1'b1);
    check("play_state", state, 2);

    // Held control between ticks does nothing
    repeat (5) cyc();
    check("no_tick_no_move", py, 208);

    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("accel_up_%0d", i), py, accel[i]);
    end
    up = 1'b0; tick();
    check("release_hold", py, 157);
    dn = 1'b1; tick();
    check("down_restart", py, 159);

    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("clamp_le_%0d", i), int'(py <= 10'd416), 1);
    end
    check("clamp_at_max", py, 416);
    up = 1'b1; dn = 1'b1;
    repeat (2) tick();
    check("conflict_hold", py, 416);

    // Reset wins over a concurrent tick with controls held
    up = 1'b1; dn = 1'b0;
    rst = 1'b1; hc = 10'd0; vc = 10'd480;
    cyc();
    rst = 1'b0; hc = 10'd1; vc = 10'd0;
    check("midplay_reset_state", state, 0);
    check("midplay_reset_y", py, 208);
    pulse(1'b1, 1'b1);
    check("ready_start_same_cycle", state, 1);
    pulse(1'b0, 1'b1);
    check("replay_state", state, 2);
    tick();
    check("ramp_restart_0", py, 206);
    tick();
    check("ramp_restart_1", py, 203);

    // Auto tracking from home
    up = 1'b0;
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    mode = 1'b1; ball = 10'd100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("auto_%0d", i), py, autoy[i]);
    end
    repeat (3) tick();
    check("auto_hold", py, 69);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/paddle_ctrl_accel.md
# paddle_ctrl_accel

Parametrised paddle controller for the Pong datapath. It generalises the fixed-speed paddle to a configurable geometry and colour, and adds a per-frame velocity ramp (acceleration) and an automatic ball-tracking mode. It also adds an IDLE/READY/PLAY game-state gate. It sits between the VGA sync counters and the RGB mixer, one instance per player, and drives 3-bit-per-channel colour plus the paddle's Y position for the ball/collision logic.

## Interface
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows; the frame tick is derived from it
- PADDLE_X, 32, left column of the paddle
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- MIN_SPEED, 2, pixels/frame on the first move frame
- MAX_SPEED, 8, velocity saturation, pixels/frame
- DEADBAND, 4, auto-mode tolerance in pixels
- PADDLE_COLOR, 9'h1FF, {R[2:0],G[2:0],B[2:0]} drawn inside the paddle
- i_Clk  in  1  pixel clock
- i_Reset  in  1  synchronous, active-high reset
- i_H_count  in  10  horizontal counter, 0..799
- i_V_count  in  10  vertical counter, 0..524
- i_Up_Ctrl  in  1  move-up request (manual mode)
- i_Down_Ctrl  in  1  move-down request (manual mode)
- i_Ready  in  1  single-cycle pulse: IDLE→READY
- i_Start  in  1  single-cycle pulse: READY→PLAY
- i_Mode  in  1  0 = manual, 1 = auto-track i_Ball_Y
- i_Ball_Y  in  10  ball centre row (auto mode)
- o_Paddle_Y  out  10  current top row of the paddle
- o_State  out  2  0 = IDLE, 1 = READY, 2 = PLAY
- o_Active  out  1  current pixel lies inside the paddle (registered)
- o_Red / o_Green / o_Blue  out  3 each  pixel colour (registered)

## Operation
- Reset: state IDLE; o_Paddle_Y = Y_HOME = (ACTIVE_ROWS−PADDLE_H)/2 (208 with the defaults); velocity = MIN_SPEED; o_Active = 0; RGB = 0.
- FSM: IDLE --i_Ready--> READY --i_Start--> PLAY. PLAY is left only by reset. In IDLE and READY the paddle stays at Y_HOME and is still drawn. i_Start in IDLE is ignored. Encoding 3 is unreachable; if entered, the FSM returns to IDLE.
- Frame tick: asserted when i_H_count == 0 and i_V_count == ACTIVE_ROWS. This is the first vblank line, so a position change never occurs mid-frame.
- Direction, evaluated only on a frame tick in PLAY:
  - manual mode: up = Up & ~Down, down = Down & ~Up; both high or both low means none.
  - auto mode: centre = Y + PADDLE_H/2. Up if centre > Ball_Y + DEADBAND; down if centre + DEADBAND < Ball_Y; otherwise none.
- Velocity:
  - The move uses the current velocity.
  - If the direction is the same as on the previous tick, velocity then increments and saturates at MAX_SPEED.
  - On none, on a direction reversal, or on a mode change, velocity returns to MIN_SPEED. The move on a reversal tick uses MIN_SPEED.
- Position arithmetic: computed in 11-bit signed form, next = Y ∓ v, then clamped to [0, ACTIVE_ROWS−PADDLE_H]. When a clamp occurs, velocity resets to MIN_SPEED.
- Pixel: Active = (PADDLE_X ≤ H < PADDLE_X+PADDLE_W) && (Y ≤ V < Y+PADDLE_H). The compare is unsigned. RGB = PADDLE_COLOR when Active, else 0.

## Timing
- o_Active and RGB are 1-cycle registered: they reflect the H/V counts sampled on the previous edge.
- o_Paddle_Y updates on the clock edge at which the tick is sampled, and is visible on the next cycle.
- o_State changes on the edge at which i_Ready or i_Start is sampled high.
- Reset has priority over every other input. Reset mid-PLAY returns the block to IDLE/Y_HOME on the next edge, regardless of held controls.
- i_Ready and i_Start asserted in the same cycle while in IDLE: only IDLE→READY is taken.
- Control and mode inputs are sampled only on the tick cycle; changes between ticks have no effect.

## Test plan
- Reset and pixel check: assert reset, then release. Required: o_State = 0, o_Paddle_Y = 208. Drive H = 34, V = 210: RGB = 9'h1FF one cycle later. Drive H = 40, V = 210: RGB = 0 one cycle later.
- Gating: hold Up across 3 ticks while in IDLE, then while in READY → Y stays at 208. Pulse Start while in IDLE → state stays 0.
- Acceleration: in PLAY, hold Up for 9 ticks → Y sequence 206, 203, 199, 194, 188, 181, 173, 165, 157. Release Up for 1 tick, then press Down → next Y = 159.
- Clamp and conflict: hold Down until the limit → Y saturates at 416 and never exceeds it. Up and Down held together for 2 ticks → Y unchanged.
- Auto mode: i_Mode = 1, i_Ball_Y = 100, starting from Y = 208 → Y decreases with the same ramp until the centre is within ±4 of 100, then holds steady.
- Reset mid-play: with Y = 50 in PLAY, assert reset for 1 cycle → next cycle o_State = 0 and Y = 208. The following ramp starts again at 2 px/frame.
